// File: rtl/tick_pkg.sv
// Shared constants for the tick generator bank: default counter width,
// channel run modes and ready-made divisors for the 50 MHz board clock.
package tick_pkg;

  localparam int DEFAULT_DIV_WIDTH = 26;
  localparam int CLOCK_HZ          = 50_000_000;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } tick_mode_e;

  localparam logic [DEFAULT_DIV_WIDTH-1:0] DIV_1HZ  = 26'd50_000_000;
  localparam logic [DEFAULT_DIV_WIDTH-1:0] DIV_2HZ  = 26'd25_000_000;
  localparam logic [DEFAULT_DIV_WIDTH-1:0] DIV_10HZ = 26'd5_000_000;
  localparam logic [DEFAULT_DIV_WIDTH-1:0] DIV_1KHZ = 26'd50_000;

  function automatic logic [DEFAULT_DIV_WIDTH-1:0] divisor_for_hz(input int hz);
    return DEFAULT_DIV_WIDTH'(CLOCK_HZ / hz);
  endfunction

endpackage

// File: rtl/tick_generator_bank_if.sv
// Control and tick bus between the light-show engines and the tick generator bank.
interface tick_generator_bank_if
  import tick_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
);

  logic [NUM_CH*DIV_WIDTH-1:0] Divisor;
  logic [NUM_CH-1:0]           Enable;
  logic [NUM_CH-1:0]           Mode;
  logic                        Sync;
  logic [NUM_CH-1:0]           Pulse;
  logic [NUM_CH-1:0]           Toggle;
  logic [NUM_CH-1:0]           Done;
  logic                        AnyPulse;

  modport master (
    output Divisor, Enable, Mode, Sync,
    input  Pulse, Toggle, Done, AnyPulse
  );

  modport slave (
    input  Divisor, Enable, Mode, Sync,
    output Pulse, Toggle, Done, AnyPulse
  );

endinterface

// File: rtl/tick_channel.sv
// One programmable tick channel: a shadowed divisor so that period changes only
// land on a terminal edge, plus a down-counter, tick pulse, toggle and one-shot flag.
module tick_channel
  import tick_pkg::*;
#(
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 enable,
  input  logic                 mode,
  input  logic                 sync,
  output logic                 pulse,
  output logic                 toggle,
  output logic                 done,
  output logic                 pulse_nxt
);

  logic [DIV_WIDTH-1:0] shadow, count;
  logic [DIV_WIDTH-1:0] shadow_nxt, count_nxt, reload;
  logic                 toggle_nxt, done_nxt;

  // A zero divisor parks the counter at zero instead of wrapping it.
  assign reload = (divisor == '0) ? '0 : divisor - DIV_WIDTH'(1);

  always_comb begin
    shadow_nxt = shadow;
    count_nxt  = count;
    pulse_nxt  = 1'b0;
    toggle_nxt = toggle;
    done_nxt   = done;

    if (sync) begin
      shadow_nxt = divisor;
      count_nxt  = reload;
      toggle_nxt = 1'b0;
      done_nxt   = 1'b0;
    end else if (done) begin
      if (mode == MODE_PERIODIC) begin
        done_nxt   = 1'b0;
        shadow_nxt = divisor;
        count_nxt  = reload;
      end
    end else if (enable) begin
      if (shadow == '0) begin
        shadow_nxt = divisor;
        count_nxt  = reload;
      end else if (count != '0) begin
        count_nxt = count - DIV_WIDTH'(1);
      end else begin
        pulse_nxt  = 1'b1;
        toggle_nxt = ~toggle;
        if (mode == MODE_ONESHOT) begin
          done_nxt = 1'b1;
        end else begin
          shadow_nxt = divisor;
          count_nxt  = reload;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      count  <= '0;
      pulse  <= 1'b0;
      toggle <= 1'b0;
      done   <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      count  <= count_nxt;
      pulse  <= pulse_nxt;
      toggle <= toggle_nxt;
      done   <= done_nxt;
    end
  end

endmodule

// File: rtl/tick_generator_bank.sv
// Bank of NUM_CH independent tick channels sharing one Sync, plus a registered
// AnyPulse that lines up exactly with the per-channel Pulse bits.
module tick_generator_bank
  import tick_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
  input logic                  Clock,
  input logic                  ResetN,
  tick_generator_bank_if.slave bus
);

  logic [NUM_CH-1:0] pulse_vec, toggle_vec, done_vec, pulse_nxt;
  logic              any_pulse;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(
      .DIV_WIDTH(DIV_WIDTH)
    ) u_channel (
      .clk       (Clock),
      .rst_n     (ResetN),
      .divisor   (bus.Divisor[i*DIV_WIDTH +: DIV_WIDTH]),
      .enable    (bus.Enable[i]),
      .mode      (bus.Mode[i]),
      .sync      (bus.Sync),
      .pulse     (pulse_vec[i]),
      .toggle    (toggle_vec[i]),
      .done      (done_vec[i]),
      .pulse_nxt (pulse_nxt[i])
    );
  end

  // Built from the channels' next-state pulses so it needs no extra stage.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      any_pulse <= 1'b0;
    end else begin
      any_pulse <= |pulse_nxt;
    end
  end

  assign bus.Pulse    = pulse_vec;
  assign bus.Toggle   = toggle_vec;
  assign bus.Done     = done_vec;
  assign bus.AnyPulse = any_pulse;

endmodule

// File: tb/tb_tick_generator_bank.sv
// Directed scenarios and a randomized soak for tick_generator_bank, each edge
// compared against a "cycles remaining until next tick" reference model.
module tb_tick_generator_bank;
  import tick_pkg::*;

  localparam int NUM_CH = 3;
  localparam int DW     = DEFAULT_DIV_WIDTH;

  logic Clock = 1'b0;
  logic ResetN;
  int   checks = 0;
  int   errors = 0;

  tick_generator_bank_if #(.NUM_CH(NUM_CH), .DIV_WIDTH(DW)) bus ();

  tick_generator_bank #(.NUM_CH(NUM_CH), .DIV_WIDTH(DW)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  // Model: latched period and enabled edges left until the tick edge.
  int                period [NUM_CH];
  int                remain [NUM_CH];
  logic [NUM_CH-1:0] m_pulse, m_toggle, m_done;
  logic              m_any;

  task automatic modelReset();
    for (int c = 0; c < NUM_CH; c++) begin
      period[c] = 0;
      remain[c] = 0;
    end
    m_pulse  = '0;
    m_toggle = '0;
    m_done   = '0;
    m_any    = 1'b0;
  endtask

  task automatic modelStep();
    int d;
    for (int c = 0; c < NUM_CH; c++) begin
      d = int'(bus.Divisor[c*DW +: DW]);
      m_pulse[c] = 1'b0;
      if (bus.Sync) begin
        period[c] = d;
        remain[c] = d;
        m_toggle[c] = 1'b0;
        m_done[c] = 1'b0;
      end else if (m_done[c]) begin
        if (!bus.Mode[c]) begin
          m_done[c] = 1'b0;
          period[c] = d;
          remain[c] = d;
        end
      end else if (bus.Enable[c]) begin
        if (period[c] == 0) begin
          period[c] = d;
          remain[c] = d;
        end else begin
          remain[c] = remain[c] - 1;
          if (remain[c] == 0) begin
            m_pulse[c] = 1'b1;
            m_toggle[c] = ~m_toggle[c];
            if (bus.Mode[c]) begin
              m_done[c] = 1'b1;
            end else begin
              period[c] = d;
              remain[c] = d;
            end
          end
        end
      end
    end
    m_any = |m_pulse;
  endtask

  task automatic checkOutput();
    checks++;
    assert (bus.Pulse === m_pulse)
      else begin errors++; $error("[TB] FAIL pulse got %b expected %b", bus.Pulse, m_pulse); end
    checks++;
    assert (bus.Toggle === m_toggle)
      else begin errors++; $error("[TB] FAIL toggle got %b expected %b", bus.Toggle, m_toggle); end
    checks++;
    assert (bus.Done === m_done)
      else begin errors++; $error("[TB] FAIL done got %b expected %b", bus.Done, m_done); end
    checks++;
    assert (bus.AnyPulse === m_any)
      else begin errors++; $error("[TB] FAIL any_pulse got %b expected %b", bus.AnyPulse, m_any); end
  endtask

  task automatic expectVec(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
      else begin errors++; $error("[TB] FAIL %s got %0h expected %0h", tag, got, exp); end
  endtask

  // Advance one rising edge with the current inputs, then compare off-edge.
  task automatic applyStimulus();
    if (!ResetN) modelReset();
    else modelStep();
    @(posedge Clock);
    #1;
    checkOutput();
  endtask

  task automatic setDiv(input int ch, input int val);
    bus.Divisor[ch*DW +: DW] = DW'(val);
  endtask

  task automatic runFromReset(input string tag);
    for (int e = 1; e <= 13; e++) begin
      applyStimulus();
      expectVec({tag, "_pulse0"}, 8'(bus.Pulse[0]), 8'(e == 5 || e == 9 || e == 13));
      expectVec({tag, "_toggle0"}, 8'(bus.Toggle[0]), 8'((e >= 5 && e < 9) || e >= 13));
      expectVec({tag, "_done0"}, 8'(bus.Done[0]), 8'h00);
    end
  endtask

  initial begin
    ResetN      = 1'b0;
    bus.Divisor = '0;
    bus.Enable  = '0;
    bus.Mode    = '0;
    bus.Sync    = 1'b0;
    modelReset();
    #12;
    expectVec("reset_pulse", 8'(bus.Pulse), 8'h00);
    expectVec("reset_toggle", 8'(bus.Toggle), 8'h00);
    expectVec("reset_done", 8'(bus.Done), 8'h00);
    expectVec("reset_any", 8'(bus.AnyPulse), 8'h00);

    // Periodic from reset, D=4 on channel 0
    setDiv(0, 4);
    bus.Enable = '1;
    ResetN = 1'b1;
    runFromReset("first");

    // Sync mid-count with ch0=5, ch1=3
    setDiv(0, 5);
    setDiv(1, 3);
    bus.Sync = 1'b1;
    applyStimulus();
    expectVec("sync_clear", 8'({bus.Pulse, bus.Toggle}), 8'h00);
    bus.Sync = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      applyStimulus();
      expectVec("sync_pulse0", 8'(bus.Pulse[0]), 8'(j == 5 || j == 10));
      expectVec("sync_pulse1", 8'(bus.Pulse[1]), 8'(j % 3 == 0));
      expectVec("sync_any", 8'(bus.AnyPulse), 8'(j % 3 == 0 || j == 5 || j == 10));
    end

    // Divisor change mid-period, then to zero
    setDiv(1, 0);
    setDiv(0, 6);
    bus.Sync = 1'b1;
    applyStimulus();
    bus.Sync = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      if (j == 3) setDiv(0, 2);
      if (j == 10) setDiv(0, 0);
      applyStimulus();
      expectVec("divchg_pulse0", 8'(bus.Pulse[0]), 8'(j == 6 || j == 8 || j == 10));
    end

    // One-shot, D=3, then back to periodic
    setDiv(0, 3);
    bus.Mode[0] = 1'b1;
    bus.Sync = 1'b1;
    applyStimulus();
    bus.Sync = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      applyStimulus();
      expectVec("oneshot_pulse0", 8'(bus.Pulse[0]), 8'(j == 3));
      expectVec("oneshot_done0", 8'(bus.Done[0]), 8'(j >= 3));
    end
    bus.Mode[0] = 1'b0;
    applyStimulus();
    expectVec("oneshot_clear", 8'(bus.Done[0]), 8'h00);
    for (int j = 1; j <= 6; j++) begin
      applyStimulus();
      expectVec("resume_pulse0", 8'(bus.Pulse[0]), 8'(j == 3 || j == 6));
    end

    // Enable dropped for 7 cycles mid-period with D=4
    setDiv(0, 4);
    bus.Sync = 1'b1;
    applyStimulus();
    bus.Sync = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      bus.Enable[0] = !(j >= 3 && j <= 9);
      applyStimulus();
      expectVec("freeze_pulse0", 8'(bus.Pulse[0]), 8'(j == 11));
    end
    bus.Enable[0] = 1'b1;

    // D=1 pulses every enabled cycle
    setDiv(0, 1);
    bus.Sync = 1'b1;
    applyStimulus();
    bus.Sync = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      applyStimulus();
      expectVec("div1_pulse0", 8'(bus.Pulse[0]), 8'h01);
      expectVec("div1_toggle0", 8'(bus.Toggle[0]), 8'(j % 2));
    end

    // Asynchronous reset mid-period, then restart timing
    setDiv(0, 4);
    bus.Sync = 1'b1;
    applyStimulus();
    bus.Sync = 1'b0;
    for (int j = 0; j < 6; j++) applyStimulus();
    #2;
    ResetN = 1'b0;
    #1;
    expectVec("async_pulse", 8'(bus.Pulse), 8'h00);
    expectVec("async_toggle", 8'(bus.Toggle), 8'h00);
    expectVec("async_done", 8'(bus.Done), 8'h00);
    expectVec("async_any", 8'(bus.AnyPulse), 8'h00);
    applyStimulus();
    setDiv(1, 0);
    setDiv(2, 0);
    bus.Mode = '0;
    bus.Enable = '1;
    ResetN = 1'b1;
    runFromReset("restart");

    // Randomized soak against the model
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(7) == 0) setDiv(c, int'($urandom_range(6)));
        bus.Enable[c] = ($urandom_range(7) != 0);
        if ($urandom_range(31) == 0) bus.Mode[c] = ~bus.Mode[c];
      end
      bus.Sync = ($urandom_range(39) == 0);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_generator_bank.md
# tick_generator_bank

Multi-channel programmable tick generator that replaces the per-purpose fixed dividers on the 50 MHz board clock. Each of NUM_CH channels divides `Clock` by its own runtime divisor and emits a one-cycle `Pulse` plus a 50 % duty `Toggle`. Each channel runs either periodic or one-shot. Divisor changes are glitch-free, and a global `Sync` re-phases all channels. It sits between the board clock and the light, display and joint pattern engines of the light show top level.

## Interface
- NUM_CH, 3, number of independent channels
- DIV_WIDTH, 26, divisor/counter width (2^26 > 50 M, so 1 Hz from 50 MHz fits)

- Clock  input  1  board clock, all logic on rising edge
- ResetN  input  1  asynchronous active-low reset
- Divisor  input  NUM_CH*DIV_WIDTH  channel i at bits [i*DIV_WIDTH +: DIV_WIDTH]; period in clocks; 0 = idle
- Enable  input  NUM_CH  per-channel count enable; low freezes count
- Mode  input  NUM_CH  0 = periodic, 1 = one-shot
- Sync  input  1  global restart of all channels, single-cycle level sampled each edge
- Pulse  output  NUM_CH  registered one-cycle tick
- Toggle  output  NUM_CH  registered; inverts on every tick
- Done  output  NUM_CH  one-shot channel has fired and is parked
- AnyPulse  output  1  registered OR of all next-cycle Pulse values

## Operation
- Per channel state: Shadow (latched divisor, DIV_WIDTH), Count (DIV_WIDTH), Pulse, Toggle, Done.
- Reset (async, ResetN=0): Shadow=0, Count=0, Pulse=0, Toggle=0, Done=0, AnyPulse=0.
- Priority per edge, highest first: Sync, then Done hold, then Enable=0 hold, then idle load, then count.
- Sync=1: every channel, regardless of Enable/Mode: Shadow<=Divisor, Count<=Divisor-1 (0 if Divisor=0), Pulse<=0, Toggle<=0, Done<=0.
- Done=1: all state held, Pulse=0. Done clears on Sync, or on the edge where Mode=0 is sampled. That edge also does the idle load below, using Shadow<=0 semantics.
- Enable=0: Count, Shadow, Toggle held; Pulse<=0.
- Idle (Shadow=0): Shadow<=Divisor, Count<=Divisor-1 if Divisor≠0; Pulse<=0. No tick from idle.
- Count≠0: Count<=Count-1, Pulse<=0.
- Count=0, Shadow≠0 (terminal): Pulse<=1, Toggle<=~Toggle, Shadow<=Divisor, Count<=Divisor-1. If Mode=1: Done<=1 and Count/Shadow are not reloaded.
- Divisor changes mid-period never truncate or extend the current period. The new value takes effect at the next terminal edge or at Sync.
- A terminal reload with Divisor=0 still issues that tick, then the channel goes idle.
- Divisor=1: Pulse high every enabled cycle, and Toggle toggles every cycle.
- Unsigned arithmetic only; Count never underflows (decrement only when ≠0).

## Timing
- Period D ≥ 1: after Sync at edge k, Pulse is high after edges k+D, k+2D, …
- From reset with constant Divisor=D and Enable=1: the first edge loads, so the first Pulse follows edge 1+D, then every D.
- Toggle period = 2D, duty 50 % for any D ≥ 1.
- AnyPulse is registered from the same next-state logic, so it is coincident with the Pulse bits (no extra latency).
- One-shot: exactly one Pulse, D cycles after Sync (or after the load edge), with Done rising on the same edge as Pulse.
- ResetN asserted mid-period: outputs go to reset values immediately (asynchronous). Deassertion is synchronised externally.

## Structure
- Package tick_pkg: DIV_WIDTH default, MODE_PERIODIC/MODE_ONESHOT constants, a 50 MHz-based divisor constant set (1 Hz, 2 Hz, 10 Hz, 1 kHz).
- Sub-module tick_channel: one channel's counter/shadow/flags, instantiated NUM_CH times by generate. The top adds the Divisor slicing and the AnyPulse OR register.

## Test plan
- Reset, Divisor ch0=4, Enable=1, Mode=0 -> Pulse[0] after edges 5, 9, 13; Toggle[0] 0→1→0 at those edges; Done=0.
- Sync mid-count with ch0=5, ch1=3 -> both Count reloaded, Pulse/Toggle cleared. Pulse[0] at k+5, k+10; Pulse[1] at k+3, k+6, k+9; AnyPulse at k+3, k+5, k+6, k+9, k+10.
- ch0 running D=6, Divisor changed to 2 at count 3 -> current period completes at 6 cycles, then ticks every 2. Later change to 0 -> one final tick, then idle, no Pulse.
- Mode=1, D=3 after Sync at k -> single Pulse at k+3, Done=1 from k+3, no further Pulse over 20 cycles. Mode→0 -> Done clears and periodic ticks resume.
- Enable dropped for 7 cycles mid-period with D=4 -> tick delayed exactly 7 cycles and Toggle frozen. D=1 -> Pulse continuously high while enabled.
- ResetN pulsed low mid-period -> all outputs 0 asynchronously; restart timing matches the first scenario.
